// File: rtl/blink_sequencer.sv
// blink_sequencer: drives one LED through a commanded blink pattern.
// A command carries an on-time, an off-time (both in prescaler ticks) and a
// pulse count. The block runs ON/OFF pulses, then an optional forced-dark
// GAP, then returns to IDLE with a one-cycle done_o pulse.
// Optional feature: define BLINK_SEQ_ABORT_EN to add an abort_i input that
// cancels a running pattern without a done_o pulse.

module blink_sequencer #(
  parameter int unsigned PrescaleValue = 100,
  parameter int unsigned CountWidth    = 8,
  parameter int unsigned RepeatWidth   = 4,
  parameter int unsigned GapTicks      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [CountWidth-1:0]  cmd_on_ticks_i,
  input  logic [CountWidth-1:0]  cmd_off_ticks_i,
  input  logic [RepeatWidth-1:0] cmd_repeat_i,
`ifdef BLINK_SEQ_ABORT_EN
  input  logic                   abort_i,
`endif
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   led_o
);

  // Prescaler width; a prescale of 1 still needs a one-bit register.
  localparam int unsigned PreW = (PrescaleValue > 1) ? $clog2(PrescaleValue) : 1;

  // The phase tick counter must hold both the command fields and the gap length.
  localparam int unsigned GapW  = (GapTicks > 0) ? $clog2(GapTicks + 1) : 1;
  localparam int unsigned TickW = (CountWidth > GapW) ? CountWidth : GapW;

  localparam logic [PreW-1:0]  PreLast = PreW'(PrescaleValue - 1);
  localparam logic [TickW-1:0] GapLen  = TickW'(GapTicks);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic                   done_q;
  logic                   done_d;

  logic [PreW-1:0]        presc_q;
  logic [TickW-1:0]       tick_cnt_q;
  logic [RepeatWidth-1:0] pulse_cnt_q;

  logic [CountWidth-1:0]  on_q;
  logic [CountWidth-1:0]  off_q;
  logic [RepeatWidth-1:0] rep_q;

  logic                   accept;
  logic                   degenerate;
  logic                   tick;
  logic [TickW-1:0]       phase_len;
  logic                   phase_last;
  logic                   last_pulse;
  logic                   abort_hit;

  assign accept     = cmd_valid_i && (state_q == IDLE);
  assign degenerate = (cmd_on_ticks_i == '0) || (cmd_repeat_i == '0);
  assign tick       = (state_q != IDLE) && (presc_q == PreLast);
  assign last_pulse = (pulse_cnt_q == (rep_q - RepeatWidth'(1)));
  assign phase_last = (tick_cnt_q == (phase_len - TickW'(1)));

`ifdef BLINK_SEQ_ABORT_EN
  assign abort_hit = abort_i && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign led_o       = (state_q == ON);
  assign done_o      = done_q;

  // Length of the current phase in ticks; a zero off-time is stretched to one
  // tick so consecutive pulses never merge into one long pulse.
  always_comb begin
    phase_len = '0;
    case (state_q)
      ON:      phase_len = TickW'(on_q);
      OFF:     phase_len = (off_q == '0) ? TickW'(1) : TickW'(off_q);
      GAP:     phase_len = GapLen;
      default: phase_len = '0;
    endcase
  end

  // Next-state and completion logic; abort overrides any phase transition.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (degenerate) begin
            done_d = 1'b1;
          end else begin
            state_d = ON;
          end
        end
      end
      ON: begin
        if (tick && phase_last) begin
          state_d = OFF;
        end
      end
      OFF: begin
        if (tick && phase_last) begin
          if (!last_pulse) begin
            state_d = ON;
          end else if (GapTicks > 0) begin
            state_d = GAP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick && phase_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // State register and registered completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Capture the command fields when a command is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      on_q  <= '0;
      off_q <= '0;
      rep_q <= '0;
    end else if (accept) begin
      on_q  <= cmd_on_ticks_i;
      off_q <= cmd_off_ticks_i;
      rep_q <= cmd_repeat_i;
    end
  end

  // Prescaler: held at zero in IDLE so every pattern starts on a fresh tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else if ((state_q == IDLE) || (state_d == IDLE) || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PreW'(1);
    end
  end

  // Ticks elapsed in the current phase; restarts on every phase change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q <= '0;
    end else if ((state_q == IDLE) || (state_d != state_q)) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  // Completed OFF phases that lead into another pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pulse_cnt_q <= '0;
    end else if (state_d == IDLE) begin
      pulse_cnt_q <= '0;
    end else if ((state_q == OFF) && (state_d == ON)) begin
      pulse_cnt_q <= pulse_cnt_q + RepeatWidth'(1);
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: directed testbench for blink_sequencer.
// Cycle n is the clock period following the nth rising edge after the
// command-accept edge (edge 0); outputs are sampled on the falling edge.

module tb_blink_sequencer;

  localparam int unsigned PrescaleValue = 4;
  localparam int unsigned CountWidth    = 8;
  localparam int unsigned RepeatWidth   = 4;
  localparam int unsigned GapTicks      = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic [CountWidth-1:0]  cmd_on_ticks_i;
  logic [CountWidth-1:0]  cmd_off_ticks_i;
  logic [RepeatWidth-1:0] cmd_repeat_i;
  logic                   busy_o;
  logic                   done_o;
  logic                   led_o;
`ifdef BLINK_SEQ_ABORT_EN
  logic                   abort_i;
`endif

  int checks = 0;
  int errors = 0;

  // Full-scale pattern probe points: on=255, off=255, repeat=15.
  int fs_cyc  [11] = '{1, 1020, 1021, 2040, 2041, 28561, 30600, 30601, 30616, 30617, 30618};
  int fs_led  [11] = '{1, 1,    0,    0,    1,    1,     0,     0,     0,     0,     0};
  int fs_busy [11] = '{1, 1,    1,    1,    1,    1,     1,     1,     1,     0,     0};
  int fs_done [11] = '{0, 0,    0,    0,    0,    0,     0,     0,     0,     1,     0};

  blink_sequencer #(
    .PrescaleValue (PrescaleValue),
    .CountWidth    (CountWidth),
    .RepeatWidth   (RepeatWidth),
    .GapTicks      (GapTicks)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_ready_o     (cmd_ready_o),
    .cmd_on_ticks_i  (cmd_on_ticks_i),
    .cmd_off_ticks_i (cmd_off_ticks_i),
    .cmd_repeat_i    (cmd_repeat_i),
`ifdef BLINK_SEQ_ABORT_EN
    .abort_i         (abort_i),
`endif
    .busy_o          (busy_o),
    .done_o          (done_o),
    .led_o           (led_o)
  );

  // Free-running clock, period 10.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input int cyc, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input int cyc, input logic exp_led,
                            input logic exp_busy, input logic exp_done);
    checkOutput({tag, ".led"},   cyc, led_o,       exp_led);
    checkOutput({tag, ".busy"},  cyc, busy_o,      exp_busy);
    checkOutput({tag, ".done"},  cyc, done_o,      exp_done);
    checkOutput({tag, ".ready"}, cyc, cmd_ready_o, !exp_busy);
  endtask

  // Present a command so that the next rising edge is edge 0.
  task automatic applyStimulus(input logic [CountWidth-1:0] on_t, input logic [CountWidth-1:0] off_t,
                               input logic [RepeatWidth-1:0] rep, input bit hold);
    @(negedge clk_i);
    cmd_on_ticks_i  = on_t;
    cmd_off_ticks_i = off_t;
    cmd_repeat_i    = rep;
    cmd_valid_i     = 1'b1;
    @(posedge clk_i);
    #1;
    if (!hold) cmd_valid_i = 1'b0;
  endtask

  // Nominal on=2/off=1/repeat=3 waveform checked over cycles 1..55.
  task automatic checkNominal(input string tag);
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk_i);
      checkCycle(tag, c,
                 (c >= 1 && c <= 8) || (c >= 13 && c <= 20) || (c >= 25 && c <= 32),
                 (c >= 1 && c <= 52),
                 (c == 53));
    end
  endtask

  initial begin
    rst_ni          = 1'b0;
    cmd_valid_i     = 1'b0;
    cmd_on_ticks_i  = '0;
    cmd_off_ticks_i = '0;
    cmd_repeat_i    = '0;
`ifdef BLINK_SEQ_ABORT_EN
    abort_i         = 1'b0;
`endif

    // Reset state
    #1;
    checkCycle("reset", -1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkCycle("post_reset", 0, 1'b0, 1'b0, 1'b0);

    // Nominal pattern
    applyStimulus(8'd2, 8'd1, 4'd3, 1'b0);
    checkNominal("nominal");

    // Degenerate: repeat = 0
    applyStimulus(8'd2, 8'd1, 4'd0, 1'b0);
    @(negedge clk_i);
    checkCycle("degen_rep", 1, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    checkCycle("degen_rep", 2, 1'b0, 1'b0, 1'b0);

    // Degenerate: on = 0
    applyStimulus(8'd0, 8'd1, 4'd3, 1'b0);
    @(negedge clk_i);
    checkCycle("degen_on", 1, 1'b0, 1'b0, 1'b1);
    @(negedge clk_i);
    checkCycle("degen_on", 2, 1'b0, 1'b0, 1'b0);

    // Zero off-time, fields changed while busy, second command held valid
    applyStimulus(8'd1, 8'd0, 4'd2, 1'b1);
    cmd_on_ticks_i  = 8'd1;
    cmd_off_ticks_i = 8'd1;
    cmd_repeat_i    = 4'd1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      checkCycle("b2b", c,
                 (c >= 1 && c <= 4) || (c >= 9 && c <= 12) || (c >= 34 && c <= 37),
                 (c >= 1 && c <= 32) || (c >= 34 && c <= 57),
                 (c == 33) || (c == 58));
      if (c == 34) cmd_valid_i = 1'b0;
    end

    // Asynchronous reset in the middle of an ON phase
    applyStimulus(8'd2, 8'd1, 4'd3, 1'b0);
    repeat (3) @(negedge clk_i);
    checkCycle("rst_mid", 3, 1'b1, 1'b1, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    checkCycle("rst_async", 3, 1'b0, 1'b0, 1'b0);
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk_i);
      checkCycle("rst_hold", c, 1'b0, 1'b0, 1'b0);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkCycle("rst_release", 6, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'd2, 8'd1, 4'd3, 1'b0);
    checkNominal("after_rst");

`ifdef BLINK_SEQ_ABORT_EN
    // Abort at cycle 10 of the nominal pattern
    applyStimulus(8'd2, 8'd1, 4'd3, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_i);
      checkCycle("abort10", c, (c >= 1 && c <= 8), (c <= 10), 1'b0);
      abort_i = (c == 10);
    end
    abort_i = 1'b0;

    // Abort held at the accept edge (ignored), then coincident with the final tick
    abort_i = 1'b1;
    applyStimulus(8'd2, 8'd1, 4'd3, 1'b0);
    abort_i = 1'b0;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk_i);
      checkCycle("abort_last", c,
                 (c >= 1 && c <= 8) || (c >= 13 && c <= 20) || (c >= 25 && c <= 32),
                 (c >= 1 && c <= 52),
                 1'b0);
      abort_i = (c == 52);
    end
    abort_i = 1'b0;
`endif

    // Full-scale fields: no counter overflow or wrap
    applyStimulus(8'd255, 8'd255, 4'd15, 1'b0);
    begin
      int idx;
      idx = 0;
      for (int c = 1; c <= 30618; c++) begin
        @(negedge clk_i);
        if (idx < 11 && c == fs_cyc[idx]) begin
          checkCycle("fullscale", c, fs_led[idx] != 0, fs_busy[idx] != 0, fs_done[idx] != 0);
          idx++;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Controller that drives a single LED output through command-driven blink patterns. Each command gives an on-time, an off-time and a repeat count.
- Sits between firmware/status logic and the board LED, and replaces free-running blink counters where a countable, sequenced pattern is required (e.g. error codes).
- Time base is an internal prescaler that divides clk_i into "ticks"; every phase length is a whole number of ticks.

Parameters:
- PrescaleValue, 100, clk_i cycles per tick; legal range ≥1.
- CountWidth, 8, width of the on/off tick fields.
- RepeatWidth, 4, width of the repeat field.
- GapTicks, 4, ticks of forced-dark gap after the final pulse; 0 means no gap.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active low
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  sequencer can accept a command
- cmd_on_ticks_i  input  CountWidth  LED-on length per pulse, in ticks
- cmd_off_ticks_i  input  CountWidth  LED-off length after each pulse, in ticks
- cmd_repeat_i  input  RepeatWidth  number of pulses
- busy_o  output  1  pattern in progress
- done_o  output  1  one-cycle completion pulse
- led_o  output  1  LED drive, active high

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- Reset values: led_o=0, done_o=0, busy_o=0, cmd_ready_o=1, state IDLE, prescaler and all counters 0.
- States: IDLE, ON, OFF, GAP. Outputs are combinational from state:
  - cmd_ready_o = (state==IDLE)
  - busy_o = (state!=IDLE)
  - led_o = (state==ON)
- Accept: when cmd_valid_i && cmd_ready_o at a rising edge, latch all three fields. cmd_valid_i is ignored while busy; no queueing.
- Prescaler: cleared on accept. Counts 0..PrescaleValue-1 while busy and emits an internal tick on the last count. A phase of N ticks therefore lasts exactly N*PrescaleValue clk_i cycles.
- Transitions:
  - IDLE→ON: cycle after accept; led_o rises in the first cycle after the accept edge.
  - ON→OFF: after on_ticks ticks.
  - OFF→ON: after off_eff ticks, if pulses remain.
  - OFF→GAP: after the last pulse's OFF phase, when GapTicks>0.
  - OFF→IDLE: after the last pulse's OFF phase, when GapTicks==0.
  - GAP→IDLE: after GapTicks ticks.
- off_eff = max(cmd_off_ticks_i, 1), so consecutive pulses never merge.
- done_o: high for exactly the one cycle in which state returns to IDLE. cmd_ready_o is also high in that cycle, so back-to-back commands are accepted with zero dead cycles.
- Degenerate commands: if repeat==0 or on_ticks==0, enter no pattern state. led_o stays 0, done_o pulses the cycle after accept, and cmd_ready_o stays high.
- Pulse counter: counts completed OFF phases and compares against the latched repeat. Full-scale values (255 ticks, 15 repeats) must work with no overflow or wrap.
- Reset mid-pattern: led_o drops immediately (asynchronous); no done_o; after release the block is IDLE and ready.

Optional Feature:
- Macro: BLINK_SEQ_ABORT_EN.
- Defined: adds port abort_i (input, 1).
  - abort_i high at an edge in any non-IDLE state forces IDLE at that edge.
  - led_o=0 and cmd_ready_o=1 from the next cycle.
  - done_o is not pulsed.
  - Abort takes priority over phase transitions in the same cycle; abort_i in IDLE has no effect.
  - Accept and abort at the same edge: accept wins, because the block was IDLE.
- Not defined: no abort_i port; a pattern can only be ended by completion or reset.

Test Plan:
- Nominal (PrescaleValue=4, GapTicks=4). Stimulus: on=2, off=1, repeat=3 accepted at edge 0. Required response:
  - led_o high cycles 1–8, 13–20 and 25–32, low otherwise.
  - GAP cycles 37–52.
  - done_o high only at cycle 53; busy_o high cycles 1–52.
- Degenerate: repeat=0, then separately on=0 → led_o never rises; done_o pulses at cycle 1; busy_o stays 0.
- Zero off / back-to-back: off=0, repeat=2, on=1 → 4-cycle low gap between pulses. A second command held valid is accepted in the done_o cycle, and led_o rises the next cycle.
- Busy ignore: change fields and hold cmd_valid_i mid-pattern → pattern unchanged; cmd_ready_o stays 0 until done.
- Async reset: assert rst_ni=0 mid-ON phase → led_o=0 with no clock edge; no done_o; after release, cmd_ready_o=1 and a new command runs to nominal timing.
- Abort (BLINK_SEQ_ABORT_EN): abort_i at cycle 10 of the nominal case → led_o=0 and idle from cycle 11; done_o never asserted. Simultaneous abort and final tick → no done_o.
